// File: rtl/us_pkg.sv
// Shared FSM encoding and default timing constants for the ultrasonic scan scheduler.
package us_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRIG   = 2'd1,
        ST_LISTEN = 2'd2,
        ST_GAP    = 2'd3
    } us_state_t;

    localparam int DEF_PRE_CYC  = 50;
    localparam int DEF_TRIG_CYC = 500;
    localparam int DEF_SLOT_CYC = 50000;
    localparam int DEF_THRESH   = 20000;

    localparam int WIDTH_W = 22;
    localparam int SLOT_W  = 16;
    localparam logic [WIDTH_W-1:0] WIDTH_MAX = '1;
endpackage

// File: rtl/us_echo_timer.sv
// Echo synchroniser, edge detector and saturating high-time counter; cleared at each slot start.
module us_echo_timer
    import us_pkg::*;
(
    input  logic               clk_50M,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               arm,
    input  logic               echo_rx,
    output logic               fall,
    output logic [WIDTH_W-1:0] width
);
    logic sync1, sync2, echo_d;
    logic seen, done;
    logic rise;

    assign rise = sync2 & ~echo_d;
    // Only the first pulse after arming is measured; done freezes the count.
    assign fall = arm & seen & ~done & ~sync2;

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            echo_d <= 1'b0;
            seen   <= 1'b0;
            done   <= 1'b0;
            width  <= '0;
        end else begin
            sync1  <= echo_rx;
            sync2  <= sync1;
            echo_d <= sync2;
            if (clr) begin
                seen  <= 1'b0;
                done  <= 1'b0;
                width <= '0;
            end else if (arm && !done) begin
                if (!seen) begin
                    if (rise) begin
                        seen  <= 1'b1;
                        width <= WIDTH_W'(1);
                    end
                end else if (sync2) begin
                    if (width != WIDTH_MAX) width <= width + WIDTH_W'(1);
                end else begin
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/us_scan_scheduler.sv
// Round-robin ultrasonic trigger/listen scheduler: one fixed-length slot per masked-in channel.
module us_scan_scheduler
    import us_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int PRE_CYC  = DEF_PRE_CYC,
    parameter int TRIG_CYC = DEF_TRIG_CYC,
    parameter int SLOT_CYC = DEF_SLOT_CYC,
    parameter int THRESH   = DEF_THRESH
) (
    input  logic               clk_50M,
    input  logic               reset_n,
    input  logic               en,
    input  logic [N_CH-1:0]    ch_mask,
    input  logic [N_CH-1:0]    echo_rx,
    output logic [N_CH-1:0]    trigger,
    output logic [WIDTH_W-1:0] pulses,
    output logic [1:0]         ch_idx,
    output logic               meas_valid,
    output logic [N_CH-1:0]    obstacle,
    output logic [1:0]         state
);
    localparam logic [SLOT_W-1:0] TRIG_ON   = SLOT_W'(PRE_CYC);
    localparam logic [SLOT_W-1:0] TRIG_OFF  = SLOT_W'(PRE_CYC + TRIG_CYC);
    localparam logic [SLOT_W-1:0] TRIG_LAST = SLOT_W'(PRE_CYC + TRIG_CYC - 1);
    localparam logic [SLOT_W-1:0] PUB_CNT   = SLOT_W'(SLOT_CYC - 2);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYC - 1);

    us_state_t         cur_state, state_d;
    logic [SLOT_W-1:0] slot_cnt, slot_d;
    logic [1:0]        cur, cur_d, sel_ch, cand;
    logic              sel_ok, can_go, publish, tclr;
    logic [N_CH-1:0]   echo_fall;
    logic              fall;
    logic [WIDTH_W-1:0] width;

    us_echo_timer u_timer (
        .clk_50M (clk_50M),
        .reset_n (reset_n),
        .clr     (tclr),
        .arm     (cur_state == ST_LISTEN),
        .echo_rx (echo_rx[cur]),
        .fall    (fall),
        .width   (width)
    );

    assign echo_fall = '0;
    assign state     = cur_state;
    assign trigger   = (cur_state == ST_TRIG && slot_cnt >= TRIG_ON && slot_cnt < TRIG_OFF)
                       ? (N_CH'(1) << cur) : '0;

    // First masked-in channel after cur; descending scan leaves the nearest one in sel_ch.
    always_comb begin
        sel_ch = cur;
        sel_ok = 1'b0;
        cand   = '0;
        for (int i = N_CH; i >= 1; i--) begin
            cand = 2'((int'(cur) + i) % N_CH);
            if (ch_mask[cand]) begin
                sel_ch = cand;
                sel_ok = 1'b1;
            end
        end
    end

    assign can_go = en & sel_ok;

    always_comb begin
        state_d = cur_state;
        slot_d  = slot_cnt + SLOT_W'(1);
        cur_d   = cur;
        publish = 1'b0;
        tclr    = 1'b0;
        case (cur_state)
            ST_IDLE: begin
                slot_d = '0;
                if (can_go) begin
                    state_d = ST_TRIG;
                    cur_d   = sel_ch;
                    tclr    = 1'b1;
                end
            end
            ST_TRIG: begin
                if (slot_cnt == TRIG_LAST) state_d = ST_LISTEN;
            end
            ST_LISTEN: begin
                if (slot_cnt == PUB_CNT) begin
                    publish = 1'b1;
                    state_d = ST_GAP;
                end else if (fall) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (slot_cnt == PUB_CNT) publish = 1'b1;
                if (slot_cnt == SLOT_LAST) begin
                    slot_d = '0;
                    if (can_go) begin
                        state_d = ST_TRIG;
                        cur_d   = sel_ch;
                        tclr    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= ST_IDLE;
            slot_cnt  <= '0;
            cur       <= 2'(N_CH - 1);
        end else begin
            cur_state <= state_d;
            slot_cnt  <= slot_d;
            cur       <= cur_d;
        end
    end

    // meas_valid is a one-cycle strobe with no ready: pulses/ch_idx/obstacle are registered
    // together with it (visible in the last slot cycle) and hold until the next publish.
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            pulses     <= '0;
            ch_idx     <= '0;
            meas_valid <= 1'b0;
            obstacle   <= '0;
        end else begin
            meas_valid <= publish;
            if (publish) begin
                pulses        <= width;
                ch_idx        <= cur;
                obstacle[cur] <= (width != '0) && (width <= WIDTH_W'(THRESH));
            end
        end
    end
endmodule

// File: tb/tb_us_scan_scheduler.sv
// Self-checking bench for us_scan_scheduler with scaled slot timing and a channel/width model.
module tb_us_scan_scheduler;
    localparam int N_CH = 4;
    localparam int PRE  = 5;
    localparam int TRG  = 50;
    localparam int SLOT = 3000;
    localparam int TH   = 1000;

    logic        clk_50M = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  ch_mask = '0;
    logic [3:0]  echo_rx = '0;
    logic [3:0]  trigger;
    logic [21:0] pulses;
    logic [1:0]  ch_idx;
    logic        meas_valid;
    logic [3:0]  obstacle;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];

    int         last_ch  = N_CH - 1;
    logic [3:0] obs_m    = '0;
    logic [3:0] sel_mask = '0;

    us_scan_scheduler #(
        .N_CH(N_CH), .PRE_CYC(PRE), .TRIG_CYC(TRG), .SLOT_CYC(SLOT), .THRESH(TH)
    ) dut (
        .clk_50M    (clk_50M),
        .reset_n    (reset_n),
        .en         (en),
        .ch_mask    (ch_mask),
        .echo_rx    (echo_rx),
        .trigger    (trigger),
        .pulses     (pulses),
        .ch_idx     (ch_idx),
        .meas_valid (meas_valid),
        .obstacle   (obstacle),
        .state      (state)
    );

    // clock / watchdog
    always #10 clk_50M = ~clk_50M;

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    // scoreboard: every publish must match the oldest predicted {ch, width}
    always @(negedge clk_50M) begin
        if (reset_n && meas_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: meas_valid with ch=%0d pulses=%0d, none expected", ch_idx, pulses);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                if ({ch_idx, pulses} !== e) begin
                    errors++;
                    $display("FAIL sb_publish: got ch=%0d w=%0d, expected ch=%0d w=%0d",
                             ch_idx, pulses, e[23:22], e[21:0]);
                end
            end
        end
    end

    function automatic int next_after(input int last, input logic [3:0] m);
        for (int i = 1; i <= N_CH; i++) begin
            if (m[(last + i) % N_CH]) return (last + i) % N_CH;
        end
        return last;
    endfunction

    // Echo high on echo_rx for slot cycles [s, s+len); seen 2 cycles later, must rise in LISTEN.
    function automatic int model_width(input int s, input int len);
        int rs, stop;
        if (len <= 0) return 0;
        rs = s + 2;
        if (rs < PRE + TRG || rs >= SLOT - 2) return 0;
        stop = (rs + len < SLOT - 2) ? rs + len : SLOT - 2;
        return stop - rs;
    endfunction

    // driver: caller sits at the negedge of slot cycle 0
    task automatic run_slot(input int s, input int len, input bit chg, input logic [3:0] nmask,
                            input int en_off_k);
        int exp_ch, exp_w, trig_err, mv_err;
        logic [3:0] exp_trig;
        exp_ch = next_after(last_ch, sel_mask);
        exp_w  = model_width(s, len);
        exp_q.push_back({2'(exp_ch), 22'(exp_w)});
        trig_err = 0;
        mv_err   = 0;
        for (int k = 0; k < SLOT; k++) begin
            echo_rx = (k >= s && k < s + len) ? (4'b0001 << exp_ch) : 4'b0000;
            if (chg && k == SLOT / 2) ch_mask = nmask;
            if (k == en_off_k) en = 1'b0;
            exp_trig = (k >= PRE && k < PRE + TRG) ? (4'b0001 << exp_ch) : 4'b0000;
            if (trigger !== exp_trig) trig_err++;
            if (meas_valid !== (k == SLOT - 1)) mv_err++;
            if (k == SLOT - 1) begin
                obs_m[exp_ch] = (exp_w != 0 && exp_w <= TH);
                checks += 3;
                if (pulses !== 22'(exp_w)) begin
                    errors++;
                    $display("FAIL pulses: got %0d expected %0d (ch %0d)", pulses, exp_w, exp_ch);
                end
                if (ch_idx !== 2'(exp_ch)) begin
                    errors++;
                    $display("FAIL ch_idx: got %0d expected %0d", ch_idx, exp_ch);
                end
                if (obstacle !== obs_m) begin
                    errors++;
                    $display("FAIL obstacle: got %b expected %b", obstacle, obs_m);
                end
            end
            @(posedge clk_50M);
            @(negedge clk_50M);
        end
        echo_rx = '0;
        last_ch = exp_ch;
        sel_mask = ch_mask;
        checks += 2;
        if (trig_err != 0) begin
            errors++;
            $display("FAIL trigger_window: %0d bad cycles on ch %0d, required 0", trig_err, exp_ch);
        end
        if (mv_err != 0) begin
            errors++;
            $display("FAIL meas_valid_timing: %0d bad cycles, required 0", mv_err);
        end
    endtask

    task automatic start_scan(input logic [3:0] m);
        @(negedge clk_50M);
        en = 1'b1;
        ch_mask = m;
        sel_mask = m;
        @(posedge clk_50M);
        @(negedge clk_50M);
    endtask

    task automatic check_idle(input string name, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_50M);
            if (state !== 2'd0 || trigger !== 4'b0 || meas_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d non-idle cycles, required 0", name, bad);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if (trigger !== 4'b0 || pulses !== 22'd0 || ch_idx !== 2'd0 || meas_valid !== 1'b0 ||
            obstacle !== 4'b0 || state !== 2'd0) begin
            errors++;
            $display("FAIL %s: trig=%b pulses=%0d ch=%0d mv=%b obs=%b st=%0d, required all 0",
                     name, trigger, pulses, ch_idx, meas_valid, obstacle, state);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk_50M);
        #1;
        check_zero_outputs("reset_state");
        @(negedge clk_50M);
        reset_n = 1'b1;
        ch_mask = 4'b1111;
        check_idle("idle_en_low", 5);
        en = 1'b1;
        ch_mask = 4'b0000;
        check_idle("idle_mask_zero", 5);
    endtask

    task automatic test_single();
        start_scan(4'b0001);
        run_slot(100, 735, 1'b0, 4'b0, -1);
    endtask

    task automatic test_round_robin();
        run_slot(200, $urandom_range(1, 900), 1'b1, 4'b1011, -1);
        run_slot($urandom_range(60, 800), $urandom_range(1, 1500), 1'b0, 4'b0, -1);
        run_slot($urandom_range(60, 800), $urandom_range(1, 1500), 1'b0, 4'b0, -1);
        run_slot($urandom_range(60, 800), $urandom_range(1, 1500), 1'b0, 4'b0, -1);
    endtask

    task automatic test_no_obstacle();
        run_slot(200, 1470, 1'b1, 4'b0100, -1);
    endtask

    task automatic test_no_echo();
        run_slot(300, 735, 1'b0, 4'b0, -1);
        run_slot(0, 0, 1'b0, 4'b0, -1);
    endtask

    task automatic test_held();
        run_slot(100, SLOT - 100, 1'b0, 4'b0, -1);
        checks++;
        if (pulses > 22'(SLOT - PRE - TRG)) begin
            errors++;
            $display("FAIL held_bound: pulses %0d above %0d", pulses, SLOT - PRE - TRG);
        end
    endtask

    task automatic test_en_drop();
        run_slot(150, 400, 1'b0, 4'b0, 1000);
        check_idle("idle_after_en_drop", 10);
    endtask

    task automatic test_random();
        logic [3:0] m;
        start_scan(4'b1111);
        run_slot(100, TH, 1'b0, 4'b0, -1);
        run_slot(100, TH + 1, 1'b0, 4'b0, -1);
        for (int r = 0; r < 4; r++) begin
            m = 4'($urandom_range(1, 15));
            run_slot($urandom_range(40, 1500), $urandom_range(0, 1400), 1'b1, m, -1);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        ch_mask = 4'b1111;
        for (int k = 0; k < 1800; k++) begin
            echo_rx = (k >= 100 && k < 1700) ? 4'b1111 : 4'b0000;
            @(posedge clk_50M);
            @(negedge clk_50M);
        end
        echo_rx = '0;
        reset_n = 1'b0;
        #1;
        check_zero_outputs("reset_mid_slot");
        last_ch = N_CH - 1;
        obs_m = '0;
        bad = 0;
        repeat (4) begin
            @(negedge clk_50M);
            if (meas_valid !== 1'b0 || trigger !== 4'b0 || state !== 2'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_hold: %0d bad cycles, required 0", bad);
        end
        reset_n = 1'b1;
        en = 1'b1;
        sel_mask = ch_mask;
        @(posedge clk_50M);
        @(negedge clk_50M);
        run_slot(120, 500, 1'b0, 4'b0, -1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_no_obstacle();
        test_no_echo();
        test_held();
        test_en_drop();
        test_random();
        test_reset_mid();
        repeat (5) @(negedge clk_50M);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_missing: %0d predicted publishes never seen, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/us_scan_scheduler.md
US_SCAN_SCHEDULER -- requirements
Module: us_scan_scheduler

Interface
REQ-001 SHALL have parameter N_CH, default 4, the number of ultrasonic channels sharing the scheduler.
REQ-002 SHALL have parameter PRE_CYC, default 50, the pre-trigger low time in cycles (1 us).
REQ-003 SHALL have parameter TRIG_CYC, default 500, the trigger high time in cycles (10 us).
REQ-004 SHALL have parameter SLOT_CYC, default 50000, the per-channel slot length in cycles (1 ms).
REQ-005 SHALL have parameter THRESH, default 20000, the obstacle threshold in echo-high cycles.
REQ-006 SHALL have port clk_50M, input, 1 bit: the 50 MHz clock, the only clock.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port en, input, 1 bit: scan enable.
REQ-009 SHALL have port ch_mask, input, N_CH bits: 1 = channel participates in the scan.
REQ-010 SHALL have port echo_rx, input, N_CH bits: raw asynchronous echo lines.
REQ-011 SHALL have port trigger, output, N_CH bits: one-hot trigger drive.
REQ-012 SHALL have port pulses, output, 22 bits: last published echo width, in cycles.
REQ-013 SHALL have port ch_idx, output, 2 bits: channel that owns pulses.
REQ-014 SHALL have port meas_valid, output, 1 bit: one-cycle publish strobe.
REQ-015 SHALL have port obstacle, output, N_CH bits: per-channel sticky-until-next-measurement flag.
REQ-016 SHALL have port state, output, 2 bits: current FSM state encoding.

Function
REQ-017 SHALL synchronise each echo_rx bit through two flops; all echo timing below refers to the synchronised signal, giving 2 cycles of latency.
REQ-018 SHALL implement FSM states IDLE=0, TRIG=1, LISTEN=2, GAP=3.
REQ-019 SHALL stay in IDLE while en=0 or ch_mask&{N_CH{1}}=0, with trigger=0.
REQ-020 SHALL select, when leaving IDLE, the next masked-in channel in round-robin order after the last served channel (wrapping N_CH-1 to 0), then clear the slot counter and enter TRIG.
REQ-021 SHALL in TRIG drive trigger[cur]=1 exactly for slot counts PRE_CYC..PRE_CYC+TRIG_CYC-1, and 0 otherwise; it SHALL enter LISTEN at count PRE_CYC+TRIG_CYC.
REQ-022 SHALL in LISTEN ignore echo until a synchronised 0-to-1 edge is seen.
REQ-023 SHALL, after that edge, increment the width counter every cycle echo=1, saturating at 22'h3FFFFF.
REQ-024 SHALL enter GAP on the falling edge of echo, or when the slot count reaches SLOT_CYC-1.
REQ-025 SHALL in GAP wait until the slot count reaches SLOT_CYC-1, then publish.
REQ-026 SHALL on publish: set pulses to the width, ch_idx to cur, assert meas_valid for 1 cycle, and set obstacle[cur]=(width!=0 && width<=THRESH).
REQ-027 SHALL, after publish, go to IDLE if en=0, otherwise select the next channel directly, with no idle cycle.
REQ-028 SHALL publish width 0 and obstacle[cur]=0 when no rising echo edge occurs in the slot.
REQ-029 SHALL take ch_mask changes effect only at channel selection; the in-flight slot always completes.
REQ-030 SHALL let en falling mid-slot finish the current slot and publish before returning to IDLE.
REQ-031 SHALL keep the slot counter at 16 bits, with SLOT_CYC <= 65535 and PRE_CYC+TRIG_CYC < SLOT_CYC.

Reset
REQ-032 SHALL, on reset_n=0, asynchronously clear state=IDLE, trigger=0, pulses=0, ch_idx=0, meas_valid=0, obstacle=0, all counters and synchronisers, and set last-served to N_CH-1 so that channel 0 is served first.
REQ-033 SHALL restart cleanly from IDLE when reset is asserted mid-slot, with no publish of the aborted slot.

Structure
REQ-034 SHALL place the state encoding and the default timing constants in a shared package us_pkg.
REQ-035 SHALL instantiate one sub-module, us_echo_timer (synchroniser, edge detect, saturating width counter), which is reset per slot.

Verification
REQ-036 SHALL cover: reset release, en=1, mask=4'b0001, echo high for 14710 cycles -> trigger[0] high for cycles 50..549; pulses=14710, ch_idx=0, obstacle[0]=1; meas_valid exactly at slot cycle 49999.
REQ-037 SHALL cover: mask=4'b1011 with continuous scan -> served order 0,1,3,0, with slot boundaries every 50000 cycles.
REQ-038 SHALL cover: echo high for 29410 cycles on channel 1 -> pulses=29410, obstacle[1]=0.
REQ-039 SHALL cover: echo held high for the whole slot -> enters GAP at slot end; pulses equals the high count (≤49450), no hang.
REQ-040 SHALL cover: no echo on channel 2 -> pulses=0, obstacle[2] cleared from a previously set value.
REQ-041 SHALL cover: reset_n pulsed low at slot cycle 30000 -> all outputs 0 immediately, meas_valid never asserted, next slot starts on channel 0.
